// File: rtl/desk_clock_timekeeper.sv
// BCD time-of-day counter with 1 s prescaler, two-button set mode and 12/24 h display mapping.
// Time/mode update one cycle after the sampled tick or button; hour12 acts combinationally; no backpressure.
module desk_clock_timekeeper #(
   parameter int CLK_DIV = 32768
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       set_btn,
   input  logic       inc_btn,
   input  logic       hour12,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hr_bcd,
   output logic       pm,
   output logic [1:0] mode,
   output logic       sec_strobe
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } mode_t;

   mode_t         state, next_state;
   logic [PW-1:0] presc;
   logic [7:0]    sec, min, hr;
   logic          strobe;

   function automatic logic [7:0] inc_mod60(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc_mod24(input logic [7:0] v);
      if (v == 8'h23)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (set_btn) next_state = SET_HR;
         SET_HR:  if (set_btn) next_state = SET_MIN;
         SET_MIN: if (set_btn) next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc  <= '0;
         sec    <= 8'h00;
         min    <= 8'h00;
         hr     <= 8'h00;
         strobe <= 1'b0;
      end else begin
         strobe <= 1'b0;
         case (state)
            RUN: begin
               if (set_btn) begin
                  // Entering SET_HR: seconds restart from zero.
                  sec   <= 8'h00;
                  presc <= '0;
               end else if (ena) begin
                  if (presc == PRESC_MAX) begin
                     presc  <= '0;
                     strobe <= 1'b1;
                     sec    <= inc_mod60(sec);
                     if (sec == 8'h59) begin
                        min <= inc_mod60(min);
                        if (min == 8'h59) hr <= inc_mod24(hr);
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
            end
            SET_HR: begin
               presc <= '0;
               if (inc_btn && !set_btn) hr <= inc_mod24(hr);
            end
            SET_MIN: begin
               presc <= '0;
               if (inc_btn && !set_btn) min <= inc_mod60(min);
            end
            default: presc <= '0;
         endcase
      end
   end

   // 12-hour view: 00 shows as 12, 13..23 fold down to 01..11.
   always_comb begin
      hr_bcd = hr;
      pm     = 1'b0;
      if (hour12) begin
         pm = (hr >= 8'h12);
         case (hr)
            8'h00:   hr_bcd = 8'h12;
            8'h13:   hr_bcd = 8'h01;
            8'h14:   hr_bcd = 8'h02;
            8'h15:   hr_bcd = 8'h03;
            8'h16:   hr_bcd = 8'h04;
            8'h17:   hr_bcd = 8'h05;
            8'h18:   hr_bcd = 8'h06;
            8'h19:   hr_bcd = 8'h07;
            8'h20:   hr_bcd = 8'h08;
            8'h21:   hr_bcd = 8'h09;
            8'h22:   hr_bcd = 8'h10;
            8'h23:   hr_bcd = 8'h11;
            default: hr_bcd = hr;
         endcase
      end
   end

   assign sec_bcd    = sec;
   assign min_bcd    = min;
   assign mode       = state;
   assign sec_strobe = strobe;

endmodule

// File: tb/tb_desk_clock_timekeeper.sv
// Directed bench for desk_clock_timekeeper with CLK_DIV=4: inputs driven and outputs sampled on the falling edge.
module tb_desk_clock_timekeeper;

   logic       clk = 1'b0;
   logic       rst, ena, set_btn, inc_btn, hour12;
   logic [7:0] sec_bcd, min_bcd, hr_bcd;
   logic       pm, sec_strobe;
   logic [1:0] mode;

   int checks   = 0;
   int failures = 0;
   int strobes;

   always #5 clk = ~clk;

   desk_clock_timekeeper #(.CLK_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .set_btn    (set_btn),
      .inc_btn    (inc_btn),
      .hour12     (hour12),
      .sec_bcd    (sec_bcd),
      .min_bcd    (min_bcd),
      .hr_bcd     (hr_bcd),
      .pm         (pm),
      .mode       (mode),
      .sec_strobe (sec_strobe)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_set();
      set_btn = 1'b1;
      step(1);
      set_btn = 1'b0;
   endtask

   task automatic incs(input int n);
      inc_btn = 1'b1;
      step(n);
      inc_btn = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; set_btn = 1'b0; inc_btn = 1'b0; hour12 = 1'b0;
      step(2);
      rst = 1'b0; ena = 1'b1;
      chk("rst_sec", sec_bcd, 8'h00);
      chk("rst_min", min_bcd, 8'h00);
      chk("rst_hr", hr_bcd, 8'h00);
      chk("rst_mode", {6'd0, mode}, 8'd0);
      chk("rst_pm", {7'd0, pm}, 8'd0);
      chk("rst_strobe", {7'd0, sec_strobe}, 8'd0);
      hour12 = 1'b1; #1;
      chk("rst_hr12", hr_bcd, 8'h12);
      chk("rst_pm12", {7'd0, pm}, 8'd0);
      hour12 = 1'b0;

      // First second: tick on the 4th edge after reset release.
      step(3);
      chk("pre_tick_sec", sec_bcd, 8'h00);
      chk("pre_tick_strobe", {7'd0, sec_strobe}, 8'd0);
      step(1);
      chk("tick1_sec", sec_bcd, 8'h01);
      chk("tick1_strobe", {7'd0, sec_strobe}, 8'd1);
      step(1);
      chk("tick1_strobe_off", {7'd0, sec_strobe}, 8'd0);

      // SET_HR, with the 12-hour sweep along the way.
      pulse_set();
      chk("sethr_mode", {6'd0, mode}, 8'd1);
      chk("sethr_sec", sec_bcd, 8'h00);
      hour12 = 1'b1; #1;
      chk("h12_00", hr_bcd, 8'h12);
      chk("pm_00", {7'd0, pm}, 8'd0);
      incs(11); #1;
      chk("h12_11", hr_bcd, 8'h11);
      chk("pm_11", {7'd0, pm}, 8'd0);
      incs(1); #1;
      chk("h12_12", hr_bcd, 8'h12);
      chk("pm_12", {7'd0, pm}, 8'd1);
      incs(1); #1;
      chk("h12_13", hr_bcd, 8'h01);
      chk("pm_13", {7'd0, pm}, 8'd1);
      incs(10); #1;
      chk("h12_23", hr_bcd, 8'h11);
      chk("pm_23", {7'd0, pm}, 8'd1);
      hour12 = 1'b0; #1;
      chk("h24_23", hr_bcd, 8'h23);
      chk("pm_h24", {7'd0, pm}, 8'd0);
      incs(1);
      chk("hr_wrap", hr_bcd, 8'h00);
      incs(23);
      chk("hr_23", hr_bcd, 8'h23);
      chk("sethr_no_strobe", {7'd0, sec_strobe}, 8'd0);

      // SET_MIN: wrap without carry into hours, then set+inc together.
      pulse_set();
      chk("setmin_mode", {6'd0, mode}, 8'd2);
      incs(59);
      chk("min_59", min_bcd, 8'h59);
      incs(1);
      chk("min_wrap", min_bcd, 8'h00);
      chk("min_wrap_hr", hr_bcd, 8'h23);
      incs(59);
      set_btn = 1'b1; inc_btn = 1'b1;
      step(1);
      set_btn = 1'b0; inc_btn = 0;
      chk("setinc_mode", {6'd0, mode}, 8'd0);
      chk("setinc_min", min_bcd, 8'h59);
      chk("setinc_sec", sec_bcd, 8'h00);

      // Run up to 23:59:58, then through midnight.
      step(232);
      chk("run_sec58", sec_bcd, 8'h58);
      chk("run_strobe58", {7'd0, sec_strobe}, 8'd1);
      step(3);
      chk("gap_strobe", {7'd0, sec_strobe}, 8'd0);
      step(1);
      chk("t59_sec", sec_bcd, 8'h59);
      chk("t59_min", min_bcd, 8'h59);
      chk("t59_hr", hr_bcd, 8'h23);
      chk("t59_strobe", {7'd0, sec_strobe}, 8'd1);
      step(1);
      chk("t59_strobe_off", {7'd0, sec_strobe}, 8'd0);
      step(2);
      chk("pre_wrap_sec", sec_bcd, 8'h59);
      step(1);
      chk("wrap_sec", sec_bcd, 8'h00);
      chk("wrap_min", min_bcd, 8'h00);
      chk("wrap_hr", hr_bcd, 8'h00);
      chk("wrap_strobe", {7'd0, sec_strobe}, 8'd1);
      step(1);
      chk("wrap_strobe_off", {7'd0, sec_strobe}, 8'd0);

      // Freeze with ena=0 when the prescaler sits at 2.
      step(1);
      ena = 1'b0;
      strobes = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (sec_strobe) strobes++;
      end
      chk("freeze_strobes", 8'(strobes), 8'd0);
      chk("freeze_sec", sec_bcd, 8'h00);
      ena = 1'b1;
      step(1);
      chk("resume_sec_hold", sec_bcd, 8'h00);
      step(1);
      chk("resume_sec", sec_bcd, 8'h01);
      chk("resume_strobe", {7'd0, sec_strobe}, 8'd1);

      // Reset in SET_HR.
      pulse_set();
      incs(7);
      chk("pre_rst_hr", hr_bcd, 8'h07);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("mid_rst_mode", {6'd0, mode}, 8'd0);
      chk("mid_rst_hr", hr_bcd, 8'h00);
      chk("mid_rst_sec", sec_bcd, 8'h00);
      step(4);
      chk("post_rst_sec", sec_bcd, 8'h01);
      chk("post_rst_strobe", {7'd0, sec_strobe}, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
